// File: rtl/sprite_line_eval.sv
// Per-line sprite evaluator: scans OAM during hblank and builds the moving-sprite line table.
// Optional macro SPRITE_EVAL_EARLY_EXIT_EN stops the scan on the first hit beyond MAX_PER_LINE.
module sprite_line_eval #(
    parameter int NUM_SPRITES  = 64,
    parameter int MAX_PER_LINE = 8,
    parameter int SPRITE_H     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] next_row,
    output logic [5:0]  oam_addr,
    input  logic [28:0] oam_data,
    output logic [2:0]  table_addr,
    output logic        table_wren,
    output logic [28:0] table_data,
    output logic [3:0]  count,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_CLEAR = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [28:0] CLEAR_WORD = {11'h7FF, 18'h0};

    logic [2:0]  state;
    logic [10:0] row_q;
    logic        data_v;
    logic        drain_cnt;
    logic [3:0]  clr_slot;
    logic [11:0] diff;
    logic        hit;
    logic        full;
    logic        stop_scan;

    // Rows above the sprite give a negative difference, so no wrap-around hits.
    always_comb begin
        diff = {1'b0, row_q} - {2'b00, oam_data[17:8]};
        hit  = data_v && !diff[11] && (diff < 12'(SPRITE_H));
        full = (count == 4'(MAX_PER_LINE));
`ifdef SPRITE_EVAL_EARLY_EXIT_EN
        stop_scan = hit && full && (state == S_SCAN);
`else
        stop_scan = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            row_q      <= '0;
            data_v     <= 1'b0;
            drain_cnt  <= 1'b0;
            clr_slot   <= '0;
            oam_addr   <= '0;
            table_addr <= '0;
            table_wren <= 1'b0;
            table_data <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            table_wren <= 1'b0;
            done       <= 1'b0;
            // data_v marks the cycle in which oam_data belongs to an issued address
            data_v     <= (state == S_SCAN) && !stop_scan;

            if (hit) begin
                if (!full) begin
                    table_wren <= 1'b1;
                    table_addr <= count[2:0];
                    table_data <= oam_data;
                    count      <= count + 4'd1;
                end else begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        row_q    <= next_row;
                        count    <= '0;
                        overflow <= 1'b0;
                        oam_addr <= '0;
                        busy     <= 1'b1;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (stop_scan || (oam_addr == 6'(NUM_SPRITES - 1))) begin
                        drain_cnt <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        oam_addr <= oam_addr + 6'd1;
                    end
                end
                S_DRAIN: begin
                    if (!drain_cnt) begin
                        drain_cnt <= 1'b1;
                    end else if (count < 4'(MAX_PER_LINE)) begin
                        table_wren <= 1'b1;
                        table_addr <= count[2:0];
                        table_data <= CLEAR_WORD;
                        clr_slot   <= count + 4'd1;
                        state      <= S_CLEAR;
                    end else begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_CLEAR: begin
                    if (clr_slot < 4'(MAX_PER_LINE)) begin
                        table_wren <= 1'b1;
                        table_addr <= clr_slot[2:0];
                        table_data <= CLEAR_WORD;
                        clr_slot   <= clr_slot + 4'd1;
                    end else begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
